sync_fifo_ctrl: RTL and testbench
=================================

// Module: sync_fifo_ctrl
// PURPOSE
//  Single-clock, parametrised FIFO: successor to the dual-clock FIFO for same-domain buffering.
//  Adds occupancy count, programmable almost-full/almost-empty thresholds, read-valid strobe
//  and optional sticky overflow/underflow flags. Sits between a producer and a consumer in one domain.
// PARAMETERS
//  DEPTH      256  entries; power of 2, >= 4
//  DATA_WIDTH 8    bits per entry
//  ADDR_WIDTH $clog2(DEPTH)  derived; not overridden
//  AF_THRESH  DEPTH-4  almost_full asserts when count >= AF_THRESH
//  AE_THRESH  4        almost_empty asserts when count <= AE_THRESH
// PORTS
//  clk          in   1             single clock, rising edge
//  rst          in   1             asynchronous, active-high reset
//  wr_en        in   1             write request
//  data_in      in   DATA_WIDTH    write data
//  rd_en        in   1             read request
//  data_out     out  DATA_WIDTH    read data, registered
//  rd_valid     out  1             data_out updated this cycle
//  full         out  1             count == DEPTH
//  empty        out  1             count == 0
//  almost_full  out  1             count >= AF_THRESH
//  almost_empty out  1             count <= AE_THRESH
//  count        out  ADDR_WIDTH+1  occupancy, 0..DEPTH
//  overflow     out  1             sticky; only with SYNC_FIFO_ERR_EN
//  underflow    out  1             sticky; only with SYNC_FIFO_ERR_EN
//  err_clr      in   1             clears sticky flags; only with SYNC_FIFO_ERR_EN
// BEHAVIOUR
//  - Reset (async assert, sync release): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, almost_empty=1,
//    almost_full=0, data_out=0, rd_valid=0, overflow=underflow=0. Memory contents not cleared.
//  - Write accepted iff wr_en && !full; stored at wr_ptr; wr_ptr increments, wraps DEPTH-1 -> 0.
//  - Read accepted iff rd_en && !empty; mem[rd_ptr] -> data_out at next edge; rd_valid=1 that cycle;
//    rd_ptr increments with wrap. Latency rd_en->data_out = 1 cycle. data_out holds otherwise.
//  - Flags and count all registered; reflect accepted ops of previous edge. No combinational in->out paths.
//  - Count: +1 write only, -1 read only, unchanged both or neither.
//  - Full + wr_en + rd_en: read accepted, write rejected (full is registered; no pass-through).
//  - Empty + wr_en + rd_en: write accepted, read rejected; no FWFT bypass.
//  - Reset mid-operation: in-flight ops discarded; state returns to reset values immediately.
// CONFIGURATION
//  SYNC_FIFO_ERR_EN defined: overflow sets on wr_en && full; underflow sets on rd_en && empty;
//    both hold until err_clr or rst; err_clr wins over a set in the same cycle.
//  Not defined: overflow, underflow, err_clr ports absent; rejected requests silently dropped.
// STRUCTURE
//  - sync_fifo_pkg: clog2-based addr/count width helpers, ptr_t/count_t typedefs via parameterised
//    localparams, default threshold constants.
//  - Sub-module sync_fifo_mem: simple dual-port RAM, one write port, one registered read port.
//    No reset on array.
//  - sync_fifo_ctrl owns pointers, count, flags, error logic.
// TESTING (DEPTH=16, DATA_WIDTH=8, AF_THRESH=12, AE_THRESH=4, SYNC_FIFO_ERR_EN defined)
//  1 Reset, then 16 writes 0x00..0x0F -> count=16, full=1, almost_full from count 12;
//    17th write (0xAA) -> dropped, overflow=1, count stays 16.
//  2 16 reads after test 1 -> data_out 0x00..0x0F in order, each 1 cycle after rd_en with rd_valid=1;
//    empty=1; extra read -> underflow=1, rd_valid=0, data_out holds 0x0F.
//  3 Count 8, wr_en && rd_en for 20 cycles -> count stays 8; pointers wrap; data order preserved.
//  4 Empty, wr_en && rd_en same cycle (0x55) -> write accepted, read rejected; count=1;
//    next-cycle read returns 0x55.
//  5 Full, wr_en && rd_en same cycle -> count=15, full=0; written word absent; overflow=1.
//  6 rst asserted mid-burst at count 9 -> all outputs to reset values same cycle; err_clr pulse
//    after an overflow -> overflow=0 next edge.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared width helpers, default FIFO geometry and threshold constants.
// Optional sticky error flags in sync_fifo_ctrl are enabled by SYNC_FIFO_ERR_EN.
package sync_fifo_pkg;

  localparam int DEF_DEPTH      = 256;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_AE_THRESH  = 4;
  localparam int DEF_AF_MARGIN  = 4;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit so the count can represent a completely full FIFO.
  function automatic int count_width(input int depth);
    return addr_width(depth) + 1;
  endfunction

  localparam int DEF_ADDR_WIDTH  = addr_width(DEF_DEPTH);
  localparam int DEF_COUNT_WIDTH = count_width(DEF_DEPTH);

  typedef logic [DEF_ADDR_WIDTH-1:0]  ptr_t;
  typedef logic [DEF_COUNT_WIDTH-1:0] count_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage: one write port, one registered read port (1-cycle read latency).
// No backpressure here; the controller only issues accepted reads/writes. Array is never reset.
module sync_fifo_mem #(
  parameter int DEPTH      = 256,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Only the output register is reset; it holds its value when no read is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with registered count/flags; read data 1 cycle after accepted rd_en.
// full/empty gate requests (rejected ops dropped); SYNC_FIFO_ERR_EN adds sticky overflow/underflow.
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int AF_THRESH  = DEPTH - DEF_AF_MARGIN,
  parameter int AE_THRESH  = DEF_AE_THRESH,
  localparam int ADDR_WIDTH = addr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count
`ifdef SYNC_FIFO_ERR_EN
  ,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
`endif
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_W-1:0]      count_nxt;
  logic                  wr_acc;
  logic                  rd_acc;

  // Gating uses registered flags, so a full FIFO never passes a write through.
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_comb begin
    count_nxt = count;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      rd_valid     <= 1'b0;
    end else begin
      // DEPTH is a power of two, so pointer wrap is the natural overflow.
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      count        <= count_nxt;
      full         <= (count_nxt == DEPTH_C);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AF_C);
      almost_empty <= (count_nxt <= AE_C);
      rd_valid     <= rd_acc;
    end
  end

  sync_fifo_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (data_in),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (data_out)
  );

`ifdef SYNC_FIFO_ERR_EN
  // A clear in the same cycle as a new error wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (err_clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl at DEPTH=16, AF=12, AE=4; error-flag checks follow SYNC_FIFO_ERR_EN.
`timescale 1ns/1ps
module tb_sync_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] data_in;
  logic       rd_en;
  logic [7:0] data_out;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;
  logic       err_clr;

  int n_tests = 0;
  int n_fail  = 0;
  bit done    = 1'b0;

  logic [7:0] q [$];
  logic [7:0] exp_d;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(
    .DEPTH      (16),
    .DATA_WIDTH (8),
    .AF_THRESH  (12),
    .AE_THRESH  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count)
`ifdef SYNC_FIFO_ERR_EN
    ,
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
`endif
  );

  task automatic chk(input string tag, input bit ok, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  initial begin
    #100000;
    if (!done) begin
      n_fail++;
      $error("FAIL timeout: directed sequence did not complete");
      $finish;
    end
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = 8'h00; err_clr = 1'b0;
    step(); step();
    chk("rst_count", count === 5'd0, count, 5'd0);
    chk("rst_empty", empty === 1'b1, empty, 1'b1);
    chk("rst_full", full === 1'b0, full, 1'b0);
    chk("rst_ae", almost_empty === 1'b1, almost_empty, 1'b1);
    chk("rst_af", almost_full === 1'b0, almost_full, 1'b0);
    chk("rst_dout", data_out === 8'h00, data_out, 8'h00);
    chk("rst_rdv", rd_valid === 1'b0, rd_valid, 1'b0);
`ifdef SYNC_FIFO_ERR_EN
    chk("rst_ovf", overflow === 1'b0, overflow, 1'b0);
    chk("rst_udf", underflow === 1'b0, underflow, 1'b0);
`endif
    rst = 1'b0;
    step();

    // Test 1: fill to full, then an overflow write
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; data_in = 8'(i);
      step();
      chk("t1_count", count === 5'(i + 1), count, 5'(i + 1));
      chk("t1_af", almost_full === 1'((i + 1) >= 12), almost_full, 1'((i + 1) >= 12));
      chk("t1_full", full === 1'((i + 1) == 16), full, 1'((i + 1) == 16));
    end
    data_in = 8'hAA;
    step();
    wr_en = 1'b0;
    chk("t1_ovf_count", count === 5'd16, count, 5'd16);
`ifdef SYNC_FIFO_ERR_EN
    chk("t1_ovf_flag", overflow === 1'b1, overflow, 1'b1);
`endif

    // Test 2: drain in order, then an underflow read
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      step();
      chk("t2_rdv", rd_valid === 1'b1, rd_valid, 1'b1);
      chk("t2_dout", data_out === 8'(i), data_out, 8'(i));
      chk("t2_count", count === 5'(15 - i), count, 5'(15 - i));
      chk("t2_ae", almost_empty === 1'((15 - i) <= 4), almost_empty, 1'((15 - i) <= 4));
    end
    chk("t2_empty", empty === 1'b1, empty, 1'b1);
    step();
    rd_en = 1'b0;
    chk("t2_udf_rdv", rd_valid === 1'b0, rd_valid, 1'b0);
    chk("t2_udf_dout", data_out === 8'h0F, data_out, 8'h0F);
`ifdef SYNC_FIFO_ERR_EN
    chk("t2_udf_flag", underflow === 1'b1, underflow, 1'b1);
`endif
    clear_errs();
`ifdef SYNC_FIFO_ERR_EN
    chk("clr_ovf", overflow === 1'b0, overflow, 1'b0);
    chk("clr_udf", underflow === 1'b0, underflow, 1'b0);
`endif

    // Test 3: steady-state simultaneous read/write at count 8 across pointer wrap
    q.delete();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; data_in = 8'h10 + 8'(i);
      q.push_back(data_in);
      step();
    end
    chk("t3_fill", count === 5'd8, count, 5'd8);
    for (int k = 0; k < 20; k++) begin
      wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h20 + 8'(k);
      exp_d = q.pop_front();
      q.push_back(data_in);
      step();
      chk("t3_count", count === 5'd8, count, 5'd8);
      chk("t3_rdv", rd_valid === 1'b1, rd_valid, 1'b1);
      chk("t3_dout", data_out === exp_d, data_out, exp_d);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1;
      exp_d = q.pop_front();
      step();
      chk("t3_drain", data_out === exp_d, data_out, exp_d);
    end
    rd_en = 1'b0;
    chk("t3_empty", empty === 1'b1, empty, 1'b1);

    // Test 4: simultaneous ops on empty FIFO
    wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h55;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("t4_count", count === 5'd1, count, 5'd1);
    chk("t4_rdv", rd_valid === 1'b0, rd_valid, 1'b0);
    chk("t4_empty", empty === 1'b0, empty, 1'b0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("t4_dout", data_out === 8'h55, data_out, 8'h55);
    chk("t4_rdv2", rd_valid === 1'b1, rd_valid, 1'b1);
    chk("t4_count2", count === 5'd0, count, 5'd0);
    clear_errs();

    // Test 5: simultaneous ops on full FIFO drop the write
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; data_in = 8'h30 + 8'(i);
      step();
    end
    chk("t5_full", full === 1'b1, full, 1'b1);
    wr_en = 1'b1; rd_en = 1'b1; data_in = 8'hEE;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("t5_count", count === 5'd15, count, 5'd15);
    chk("t5_notfull", full === 1'b0, full, 1'b0);
    chk("t5_dout", data_out === 8'h30, data_out, 8'h30);
`ifdef SYNC_FIFO_ERR_EN
    chk("t5_ovf", overflow === 1'b1, overflow, 1'b1);
`endif
    for (int i = 1; i < 16; i++) begin
      rd_en = 1'b1;
      step();
      chk("t5_drain", data_out === 8'h30 + 8'(i), data_out, 8'h30 + 8'(i));
    end
    rd_en = 1'b0;
    chk("t5_empty", empty === 1'b1, empty, 1'b1);
    clear_errs();

    // Test 6: asynchronous reset mid-burst, then err_clr priority
    for (int i = 0; i < 9; i++) begin
      wr_en = 1'b1; data_in = 8'h40 + 8'(i);
      step();
    end
    chk("t6_pre", count === 5'd9, count, 5'd9);
    rst = 1'b1;
    #1;
    chk("t6_count", count === 5'd0, count, 5'd0);
    chk("t6_empty", empty === 1'b1, empty, 1'b1);
    chk("t6_ae", almost_empty === 1'b1, almost_empty, 1'b1);
    chk("t6_dout", data_out === 8'h00, data_out, 8'h00);
    chk("t6_rdv", rd_valid === 1'b0, rd_valid, 1'b0);
    wr_en = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("t6_post", count === 5'd0, count, 5'd0);
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; data_in = 8'(i);
      step();
    end
`ifdef SYNC_FIFO_ERR_EN
    chk("t6_ovf_set", overflow === 1'b1, overflow, 1'b1);
`endif
    err_clr = 1'b1;
    step();
    err_clr = 1'b0; wr_en = 1'b0;
    chk("t6_full", full === 1'b1, full, 1'b1);
`ifdef SYNC_FIFO_ERR_EN
    chk("t6_ovf_clr", overflow === 1'b0, overflow, 1'b0);
`endif

    done = 1'b1;
    if (n_fail != 0) begin
      $error("FAIL summary: %0d of %0d checks failed", n_fail, n_tests);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
